// File: rtl/serial_parity_pkg.sv
// Shared types and helpers for the serial parity checker.
package serial_parity_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DATA = 2'd1,
    S_PAR  = 2'd2
  } state_t;

  // Bit counter must hold 0..frame_len inclusive.
  function automatic int count_w(input int frame_len);
    return $clog2(frame_len + 1);
  endfunction

endpackage

// File: rtl/serial_parity_if.sv
// Bit-stream input and frame-result output bundle of the serial parity checker.
interface serial_parity_if #(
  parameter int FRAME_LEN = 8,
  parameter int CNT_W     = 8
);
  logic                 in_valid;
  logic                 in_bit;
  logic                 in_sof;
  logic                 in_ready;
  logic                 out_valid;
  logic                 out_ready;
  logic [FRAME_LEN-1:0] out_data;
  logic                 out_err;
  logic                 abort;
  logic [CNT_W-1:0]     err_cnt;

  modport master (
    output in_valid, in_bit, in_sof, out_ready,
    input  in_ready, out_valid, out_data, out_err, abort, err_cnt
  );

  modport slave (
    input  in_valid, in_bit, in_sof, out_ready,
    output in_ready, out_valid, out_data, out_err, abort, err_cnt
  );
endinterface

// File: rtl/parity_acc.sv
// Single-bit XOR accumulator: clear drops the history, enable folds in a new bit.
module parity_acc (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_en,
  input  logic i_bit,
  output logic o_acc
);
  logic r_acc;

  // Clear and enable together restart the accumulator at the incoming bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= 1'b0;
    end else begin
      r_acc <= (i_clr ? 1'b0 : r_acc) ^ (i_en & i_bit);
    end
  end

  assign o_acc = r_acc;
endmodule

// File: rtl/serial_parity_checker.sv
// Deserialises LSB-first frames, checks the trailing parity bit and presents
// the word plus error flag on a valid/ready output with a saturating error count.
module serial_parity_checker
  import serial_parity_pkg::*;
#(
  parameter int FRAME_LEN  = 8,
  parameter int ODD_PARITY = 0,
  parameter int CNT_W      = 8
) (
  input logic            clk,
  input logic            rst_n,
  serial_parity_if.slave bus
);
  localparam int                 COUNT_W  = count_w(FRAME_LEN);
  localparam logic [COUNT_W-1:0] LAST_IDX = COUNT_W'(FRAME_LEN - 1);
  localparam logic [CNT_W-1:0]   CNT_MAX  = '1;
  localparam logic               ODD_BIT  = (ODD_PARITY != 0);

  state_t               r_state;
  logic [COUNT_W-1:0]   r_count;
  logic [FRAME_LEN-1:0] r_shift;
  logic [FRAME_LEN-1:0] r_out_data;
  logic                 r_out_valid;
  logic                 r_out_err;
  logic                 r_abort;
  logic [CNT_W-1:0]     r_err_cnt;

  logic                 w_in_ready;
  logic                 w_accept;
  logic                 w_start;
  logic                 w_data_accept;
  logic                 w_par_accept;
  logic                 w_acc;
  logic                 w_result;
  logic [FRAME_LEN-1:0] w_sel;
  logic [FRAME_LEN-1:0] w_shift_next;

  // Only the parity bit stalls: it would need the output register that is still occupied.
  assign w_in_ready    = !(r_state == S_PAR && r_out_valid && !bus.out_ready);
  assign w_accept      = bus.in_valid && w_in_ready;
  assign w_start       = w_accept && bus.in_sof;
  assign w_data_accept = w_accept && !bus.in_sof && (r_state == S_DATA);
  assign w_par_accept  = w_accept && !bus.in_sof && (r_state == S_PAR);
  assign w_result      = w_acc ^ bus.in_bit ^ ODD_BIT;

  parity_acc u_parity_acc (
    .clk   (clk),
    .rst_n (rst_n),
    .i_clr (w_start || w_par_accept),
    .i_en  (w_start || w_data_accept),
    .i_bit (bus.in_bit),
    .o_acc (w_acc)
  );

  genvar gi;
  generate
    for (gi = 0; gi < FRAME_LEN; gi++) begin : g_shift
      assign w_sel[gi]        = (r_count == COUNT_W'(gi));
      assign w_shift_next[gi] = ((w_start && (gi == 0)) || (w_data_accept && w_sel[gi]))
                                ? bus.in_bit : r_shift[gi];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_count     <= '0;
      r_shift     <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_out_err   <= 1'b0;
      r_abort     <= 1'b0;
      r_err_cnt   <= '0;
    end else begin
      r_shift <= w_shift_next;
      r_abort <= 1'b0;
      if (r_out_valid && bus.out_ready) begin
        r_out_valid <= 1'b0;
      end
      if (w_accept) begin
        case (r_state)
          S_IDLE: begin
            if (bus.in_sof) begin
              r_count <= COUNT_W'(1);
              r_state <= S_DATA;
            end
          end
          S_DATA: begin
            if (bus.in_sof) begin
              r_abort <= 1'b1;
              r_count <= COUNT_W'(1);
            end else begin
              r_count <= r_count + COUNT_W'(1);
              if (r_count == LAST_IDX) begin
                r_state <= S_PAR;
              end
            end
          end
          S_PAR: begin
            if (bus.in_sof) begin
              r_abort <= 1'b1;
              r_count <= COUNT_W'(1);
              r_state <= S_DATA;
            end else begin
              // A load in the same cycle as a consume overrides the clear above.
              r_out_valid <= 1'b1;
              r_out_data  <= r_shift;
              r_out_err   <= w_result;
              if (w_result && r_err_cnt != CNT_MAX) begin
                r_err_cnt <= r_err_cnt + CNT_W'(1);
              end
              r_count <= '0;
              r_state <= S_IDLE;
            end
          end
          default: begin
            r_count <= '0;
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_err   = r_out_err;
  assign bus.abort     = r_abort;
  assign bus.err_cnt   = r_err_cnt;
endmodule

// File: tb/tb_serial_parity_checker.sv
// Directed bench: even, odd and narrow-counter instances share one bit stream.
module tb_serial_parity_checker;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic drv_valid, drv_bit, drv_sof, drv_ready;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  serial_parity_if #(.FRAME_LEN(8), .CNT_W(8)) if_e ();
  serial_parity_if #(.FRAME_LEN(8), .CNT_W(8)) if_o ();
  serial_parity_if #(.FRAME_LEN(8), .CNT_W(2)) if_s ();

  assign if_e.in_valid = drv_valid;
  assign if_e.in_bit = drv_bit;
  assign if_e.in_sof = drv_sof;
  assign if_e.out_ready = drv_ready;
  assign if_o.in_valid = drv_valid;
  assign if_o.in_bit = drv_bit;
  assign if_o.in_sof = drv_sof;
  assign if_o.out_ready = drv_ready;
  assign if_s.in_valid = drv_valid;
  assign if_s.in_bit = drv_bit;
  assign if_s.in_sof = drv_sof;
  assign if_s.out_ready = drv_ready;

  serial_parity_checker #(.FRAME_LEN(8), .ODD_PARITY(0), .CNT_W(8)) dut_e (
    .clk(clk), .rst_n(rst_n), .bus(if_e));
  serial_parity_checker #(.FRAME_LEN(8), .ODD_PARITY(1), .CNT_W(8)) dut_o (
    .clk(clk), .rst_n(rst_n), .bus(if_o));
  serial_parity_checker #(.FRAME_LEN(8), .ODD_PARITY(0), .CNT_W(2)) dut_s (
    .clk(clk), .rst_n(rst_n), .bus(if_s));

  task automatic idle();
    drv_valid = 1'b0;
    drv_bit = 1'b0;
    drv_sof = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Starts and ends on a falling edge; returns once the bit has been accepted.
  task automatic send(input logic b, input logic s);
    int n = 0;
    drv_valid = 1'b1;
    drv_bit = b;
    drv_sof = s;
    while (!if_e.in_ready && n < 20) begin
      tick();
      n++;
    end
    if (!if_e.in_ready) begin
      checks++;
      failures++;
      $display("FAIL send_timeout in_ready=%0b required=1", if_e.in_ready);
    end
    tick();
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p);
    for (int i = 0; i < 8; i++) send(d[i], i == 0);
    send(p, 1'b0);
    $display("tx frame data=%02h par=%0b -> out_valid=%0b data=%02h err=%0b err_cnt=%0d",
             d, p, if_e.out_valid, if_e.out_data, if_e.out_err, if_e.err_cnt);
  endtask

  task automatic test_reset();
    checks++; if (if_e.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%0b exp=0", if_e.out_valid); end
    checks++; if (if_e.out_data !== 8'h00) begin failures++; $display("FAIL reset_out_data got=%02h exp=00", if_e.out_data); end
    checks++; if (if_e.out_err !== 1'b0) begin failures++; $display("FAIL reset_out_err got=%0b exp=0", if_e.out_err); end
    checks++; if (if_e.abort !== 1'b0) begin failures++; $display("FAIL reset_abort got=%0b exp=0", if_e.abort); end
    checks++; if (if_e.err_cnt !== 8'd0) begin failures++; $display("FAIL reset_err_cnt got=%0d exp=0", if_e.err_cnt); end
    checks++; if (if_e.in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%0b exp=1", if_e.in_ready); end
    rst_n = 1'b1;
    tick();
    checks++; if (if_e.in_ready !== 1'b1) begin failures++; $display("FAIL post_reset_in_ready got=%0b exp=1", if_e.in_ready); end
  endtask

  task automatic test_basic();
    logic [7:0] d = 8'hA5;
    for (int i = 0; i < 8; i++) send(d[i], i == 0);
    checks++; if (if_e.out_valid !== 1'b0) begin failures++; $display("FAIL basic_early_valid got=%0b exp=0", if_e.out_valid); end
    send(1'b0, 1'b0);
    $display("tx frame data=a5 par=0 -> out_valid=%0b data=%02h err=%0b", if_e.out_valid, if_e.out_data, if_e.out_err);
    idle();
    checks++; if (if_e.out_valid !== 1'b1) begin failures++; $display("FAIL basic_valid got=%0b exp=1", if_e.out_valid); end
    checks++; if (if_e.out_data !== 8'hA5) begin failures++; $display("FAIL basic_data got=%02h exp=a5", if_e.out_data); end
    checks++; if (if_e.out_err !== 1'b0) begin failures++; $display("FAIL basic_err got=%0b exp=0", if_e.out_err); end
    checks++; if (if_e.err_cnt !== 8'd0) begin failures++; $display("FAIL basic_err_cnt got=%0d exp=0", if_e.err_cnt); end
    checks++; if (if_o.out_err !== 1'b1) begin failures++; $display("FAIL basic_odd_err got=%0b exp=1", if_o.out_err); end
    tick();
    checks++; if (if_e.out_valid !== 1'b0) begin failures++; $display("FAIL basic_consumed got=%0b exp=0", if_e.out_valid); end
  endtask

  task automatic test_parity_error();
    send_frame(8'hA5, 1'b1);
    idle();
    checks++; if (if_e.out_err !== 1'b1) begin failures++; $display("FAIL perr_err got=%0b exp=1", if_e.out_err); end
    checks++; if (if_e.err_cnt !== 8'd1) begin failures++; $display("FAIL perr_err_cnt got=%0d exp=1", if_e.err_cnt); end
    checks++; if (if_o.out_err !== 1'b0) begin failures++; $display("FAIL perr_odd_err got=%0b exp=0", if_o.out_err); end
    checks++; if (if_o.err_cnt !== 8'd1) begin failures++; $display("FAIL perr_odd_err_cnt got=%0d exp=1", if_o.err_cnt); end
    tick();
  endtask

  task automatic test_backpressure();
    drv_ready = 1'b0;
    send_frame(8'h3C, 1'b0);
    checks++; if (if_e.out_data !== 8'h3C) begin failures++; $display("FAIL bp_first_data got=%02h exp=3c", if_e.out_data); end
    for (int i = 0; i < 8; i++) begin
      checks++; if (if_e.in_ready !== 1'b1) begin failures++; $display("FAIL bp_data_ready bit=%0d got=%0b exp=1", i, if_e.in_ready); end
      send(1'b1, i == 0);
    end
    idle();
    checks++; if (if_e.in_ready !== 1'b0) begin failures++; $display("FAIL bp_par_ready got=%0b exp=0", if_e.in_ready); end
    drv_valid = 1'b1;
    tick();
    checks++; if (if_e.in_ready !== 1'b0) begin failures++; $display("FAIL bp_stall_ready got=%0b exp=0", if_e.in_ready); end
    checks++; if (if_e.out_data !== 8'h3C) begin failures++; $display("FAIL bp_held_data got=%02h exp=3c", if_e.out_data); end
    checks++; if (if_e.out_valid !== 1'b1) begin failures++; $display("FAIL bp_held_valid got=%0b exp=1", if_e.out_valid); end
    drv_ready = 1'b1;
    tick();
    idle();
    $display("tx frame data=ff par=0 -> out_valid=%0b data=%02h err=%0b", if_e.out_valid, if_e.out_data, if_e.out_err);
    checks++; if (if_e.out_valid !== 1'b1) begin failures++; $display("FAIL bp_next_valid got=%0b exp=1", if_e.out_valid); end
    checks++; if (if_e.out_data !== 8'hFF) begin failures++; $display("FAIL bp_next_data got=%02h exp=ff", if_e.out_data); end
    checks++; if (if_e.out_err !== 1'b0) begin failures++; $display("FAIL bp_next_err got=%0b exp=0", if_e.out_err); end
    tick();
    checks++; if (if_e.out_valid !== 1'b0) begin failures++; $display("FAIL bp_drained got=%0b exp=0", if_e.out_valid); end
  endtask

  task automatic test_abort();
    logic [7:0] d = 8'h5A;
    send(1'b1, 1'b1);
    for (int i = 0; i < 3; i++) send(1'b1, 1'b0);
    checks++; if (if_e.abort !== 1'b0) begin failures++; $display("FAIL abort_early got=%0b exp=0", if_e.abort); end
    send(d[0], 1'b1);
    checks++; if (if_e.abort !== 1'b1) begin failures++; $display("FAIL abort_pulse got=%0b exp=1", if_e.abort); end
    checks++; if (if_e.out_valid !== 1'b0) begin failures++; $display("FAIL abort_out_valid got=%0b exp=0", if_e.out_valid); end
    send(d[1], 1'b0);
    checks++; if (if_e.abort !== 1'b0) begin failures++; $display("FAIL abort_one_cycle got=%0b exp=0", if_e.abort); end
    for (int i = 2; i < 8; i++) send(d[i], 1'b0);
    send(1'b0, 1'b0);
    idle();
    $display("tx resync frame data=5a par=0 -> out_valid=%0b data=%02h err=%0b", if_e.out_valid, if_e.out_data, if_e.out_err);
    checks++; if (if_e.out_valid !== 1'b1) begin failures++; $display("FAIL abort_valid got=%0b exp=1", if_e.out_valid); end
    checks++; if (if_e.out_data !== 8'h5A) begin failures++; $display("FAIL abort_data got=%02h exp=5a", if_e.out_data); end
    checks++; if (if_e.out_err !== 1'b0) begin failures++; $display("FAIL abort_err got=%0b exp=0", if_e.out_err); end
    tick();
  endtask

  task automatic test_no_sof();
    for (int i = 0; i < 5; i++) begin
      send(1'b1, 1'b0);
      checks++; if (if_e.out_valid !== 1'b0) begin failures++; $display("FAIL nosof_valid bit=%0d got=%0b exp=0", i, if_e.out_valid); end
      checks++; if (if_e.abort !== 1'b0) begin failures++; $display("FAIL nosof_abort bit=%0d got=%0b exp=0", i, if_e.abort); end
    end
    idle();
  endtask

  task automatic test_reset_midframe();
    drv_ready = 1'b0;
    send_frame(8'h81, 1'b0);
    checks++; if (if_e.out_valid !== 1'b1) begin failures++; $display("FAIL mid_pending got=%0b exp=1", if_e.out_valid); end
    send(1'b1, 1'b1);
    send(1'b0, 1'b0);
    send(1'b1, 1'b0);
    idle();
    rst_n = 1'b0;
    #1;
    checks++; if (if_e.out_valid !== 1'b0) begin failures++; $display("FAIL mid_rst_valid got=%0b exp=0", if_e.out_valid); end
    checks++; if (if_e.out_data !== 8'h00) begin failures++; $display("FAIL mid_rst_data got=%02h exp=00", if_e.out_data); end
    checks++; if (if_e.err_cnt !== 8'd0) begin failures++; $display("FAIL mid_rst_err_cnt got=%0d exp=0", if_e.err_cnt); end
    checks++; if (if_e.abort !== 1'b0) begin failures++; $display("FAIL mid_rst_abort got=%0b exp=0", if_e.abort); end
    checks++; if (if_e.in_ready !== 1'b1) begin failures++; $display("FAIL mid_rst_ready got=%0b exp=1", if_e.in_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    drv_ready = 1'b1;
    tick();
    send_frame(8'hA5, 1'b0);
    idle();
    checks++; if (if_e.out_data !== 8'hA5) begin failures++; $display("FAIL mid_after_data got=%02h exp=a5", if_e.out_data); end
    checks++; if (if_e.out_err !== 1'b0) begin failures++; $display("FAIL mid_after_err got=%0b exp=0", if_e.out_err); end
    tick();
  endtask

  task automatic test_back_to_back_saturation();
    int exp_s;
    for (int k = 0; k < 5; k++) begin
      send_frame(8'hA5, 1'b1);
      exp_s = (k + 1 > 3) ? 3 : k + 1;
      checks++; if (if_s.err_cnt !== 2'(exp_s)) begin failures++; $display("FAIL sat_err_cnt frame=%0d got=%0d exp=%0d", k, if_s.err_cnt, exp_s); end
      checks++; if (if_e.err_cnt !== 8'(k + 1)) begin failures++; $display("FAIL b2b_err_cnt frame=%0d got=%0d exp=%0d", k, if_e.err_cnt, k + 1); end
      checks++; if (if_e.out_valid !== 1'b1) begin failures++; $display("FAIL b2b_valid frame=%0d got=%0b exp=1", k, if_e.out_valid); end
    end
    idle();
    tick();
  endtask

  initial begin
    idle();
    drv_ready = 1'b1;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    test_reset();
    test_basic();
    test_parity_error();
    test_backpressure();
    test_abort();
    test_no_sof();
    test_reset_midframe();
    test_back_to_back_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout time=%0t limit=200000", $time);
    $fatal(1, "bench did not complete");
  end
endmodule
